// File: rtl/cmac_pkg.sv
// Shared types and helpers for the complex MAC engine.
// Holds the FSM state enum, accumulator sizing and {re, im} bus helpers.
package cmac_pkg;

   typedef enum logic [1:0] {
      LOAD,
      FULL,
      RUN,
      DRAIN
   } cmac_state_t;

   // Wide enough that N full-scale products cannot overflow.
   function automatic int cmac_accw(input int n, input int cw);
      return 2 * cw + 1 + $clog2(n);
   endfunction

   localparam int CPLX_MAXW = 32;
   typedef logic [2*CPLX_MAXW-1:0] cplx_bus_t;

   function automatic cplx_bus_t cplx_mask(input int cw);
      return (cplx_bus_t'(1) << cw) - cplx_bus_t'(1);
   endfunction

   // Packs {re, im} with re in the upper cw bits.
   function automatic cplx_bus_t cplx_pack(
      input logic [CPLX_MAXW-1:0] re,
      input logic [CPLX_MAXW-1:0] im,
      input int                   cw
   );
      cplx_bus_t m;
      m = cplx_mask(cw);
      return ((cplx_bus_t'(re) & m) << cw)
           | (cplx_bus_t'(im) & m);
   endfunction

   function automatic logic [CPLX_MAXW-1:0] cplx_re(
      input cplx_bus_t v,
      input int        cw
   );
      cplx_bus_t s;
      s = (v >> cw) & cplx_mask(cw);
      return s[CPLX_MAXW-1:0];
   endfunction

   function automatic logic [CPLX_MAXW-1:0] cplx_im(
      input cplx_bus_t v,
      input int        cw
   );
      cplx_bus_t s;
      s = v & cplx_mask(cw);
      return s[CPLX_MAXW-1:0];
   endfunction

endpackage

// File: rtl/cmplx_mac_engine_mult.sv
// Combinational signed complex multiplier, x*y or x*conj(y).
// Ports: xr/xi/yr/yi (CW signed), conj, re/im (2CW+1 signed).
module cmplx_mult #(
   parameter int CW = 4
) (
   input  logic signed [CW-1:0] xr,
   input  logic signed [CW-1:0] xi,
   input  logic signed [CW-1:0] yr,
   input  logic signed [CW-1:0] yi,
   input  logic                 conj,
   output logic signed [2*CW:0] re,
   output logic signed [2*CW:0] im
);

   logic signed [2*CW-1:0] rr, ii, ri, ir;
   logic signed [2*CW:0]   rr_x, ii_x, ri_x, ir_x;

   assign rr = xr * yr;
   assign ii = xi * yi;
   assign ri = xr * yi;
   assign ir = xi * yr;

   assign rr_x = {rr[2*CW-1], rr};
   assign ii_x = {ii[2*CW-1], ii};
   assign ri_x = {ri[2*CW-1], ri};
   assign ir_x = {ir[2*CW-1], ir};

   assign re = conj ? rr_x + ii_x : rr_x - ii_x;
   assign im = conj ? ir_x - ri_x : ri_x + ir_x;

endmodule

// File: rtl/cmplx_mac_engine.sv
// Complex MAC engine: buffers N operand pairs, then accumulates x*y.
// Ports: load (in_valid/in_ready/x_in/y_in), run control
// (start/conj/keep), status (busy/done), results (acc_re/acc_im).
module cmplx_mac_engine
   import cmac_pkg::*;
#(
   parameter int N    = 4,
   parameter int CW   = 4,
   parameter int ACCW = cmac_accw(N, CW)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*CW-1:0]        x_in,
   input  logic [2*CW-1:0]        y_in,
   input  logic                   start,
   input  logic                   conj,
   input  logic                   keep,
   output logic                   busy,
   output logic                   done,
   output logic signed [ACCW-1:0] acc_re,
   output logic signed [ACCW-1:0] acc_im
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * CW + 1;
   localparam int EW = ACCW - PW;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   cmac_state_t state, nxt;

   logic [2*CW-1:0] x_mem [N];
   logic [2*CW-1:0] y_mem [N];
   logic [IW-1:0]   wr_idx, rd_idx;
   logic            conj_q;
   logic            load_hs, start_hs, acc_en;

   logic signed [PW-1:0] p_re, p_im;
   logic signed [PW-1:0] prod_re, prod_im;

   assign in_ready = (state == LOAD);
   assign busy     = (state == RUN) || (state == DRAIN);
   assign load_hs  = in_valid && in_ready;
   assign start_hs = (state == FULL) && start;

   // The product register is one cycle behind rd_idx, so the
   // first RUN cycle has nothing valid to add yet.
   assign acc_en = (state == DRAIN)
                || ((state == RUN) && (rd_idx != '0));

   cmplx_mult #(.CW(CW)) u_mult (
      .xr   (x_mem[rd_idx][2*CW-1:CW]),
      .xi   (x_mem[rd_idx][CW-1:0]),
      .yr   (y_mem[rd_idx][2*CW-1:CW]),
      .yi   (y_mem[rd_idx][CW-1:0]),
      .conj (conj_q),
      .re   (p_re),
      .im   (p_im)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         LOAD:    if (load_hs && wr_idx == LAST) nxt = FULL;
         FULL:    if (start) nxt = RUN;
         RUN:     if (rd_idx == LAST) nxt = DRAIN;
         DRAIN:   nxt = LOAD;
         default: nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         conj_q  <= 1'b0;
         prod_re <= '0;
         prod_im <= '0;
         acc_re  <= '0;
         acc_im  <= '0;
         done    <= 1'b0;
         for (int i = 0; i < N; i++) begin
            x_mem[i] <= '0;
            y_mem[i] <= '0;
         end
      end else begin
         done <= (state == DRAIN);
         if (load_hs) begin
            x_mem[wr_idx] <= x_in;
            y_mem[wr_idx] <= y_in;
            wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
         end
         if (start_hs) begin
            conj_q <= conj;
            rd_idx <= '0;
            if (!keep) begin
               acc_re <= '0;
               acc_im <= '0;
            end
         end
         if (state == RUN) begin
            prod_re <= p_re;
            prod_im <= p_im;
            rd_idx  <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
         end
         if (acc_en) begin
            acc_re <= acc_re + {{EW{prod_re[PW-1]}}, prod_re};
            acc_im <= acc_im + {{EW{prod_im[PW-1]}}, prod_im};
         end
      end
   end

endmodule

// File: tb/tb_cmplx_mac_engine.sv
// Directed self-checking bench for cmplx_mac_engine (N=4, CW=4).
// Expected results are hand-computed complex sums.
module tb_cmplx_mac_engine;
   import cmac_pkg::*;

   localparam int N    = 4;
   localparam int CW   = 4;
   localparam int ACCW = cmac_accw(N, CW);

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [2*CW-1:0]        x_in, y_in;
   logic                   start, conj, keep;
   logic                   busy, done;
   logic signed [ACCW-1:0] acc_re, acc_im;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cmplx_mac_engine #(.N(N), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .y_in     (y_in),
      .start    (start),
      .conj     (conj),
      .keep     (keep),
      .busy     (busy),
      .done     (done),
      .acc_re   (acc_re),
      .acc_im   (acc_im)
   );

   function automatic logic [7:0] cp(input int re, input int im);
      logic [3:0] r, i;
      r = re[3:0];
      i = im[3:0];
      return {r, i};
   endfunction

   task automatic chk(
      input string              tag,
      input logic signed [31:0] obs,
      input logic signed [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] xv, input logic [7:0] yv);
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      x_in     = xv;
      y_in     = yv;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load4(input logic [7:0] xv, input logic [7:0] yv);
      for (int k = 0; k < N; k++) load(xv, yv);
      chk("in_ready_full", in_ready, 0);
   endtask

   task automatic run(
      input logic  cj,
      input logic  kp,
      input int    er,
      input int    ei,
      input string tag
   );
      int cyc, bc;
      start = 1'b1;
      conj  = cj;
      keep  = kp;
      tick();
      start = 1'b0;
      bc  = busy ? 1 : 0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
         if (busy) bc++;
      end
      chk({tag, "_latency"}, cyc, N + 1);
      chk({tag, "_busy_cycles"}, bc, N + 1);
      chk({tag, "_re"}, acc_re, er);
      chk({tag, "_im"}, acc_im, ei);
      chk({tag, "_ready_at_done"}, in_ready, 1);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_re_hold"}, acc_re, er);
   endtask

   initial begin
      int dc;
      logic signed [ACCW-1:0] sre, sim;
      logic [7:0] a, b, m;

      a = cp(1, 2);
      b = cp(3, 4);
      m = cp(-8, -8);

      rst      = 1'b1;
      in_valid = 1'b0;
      x_in     = '0;
      y_in     = '0;
      start    = 1'b0;
      conj     = 1'b0;
      keep     = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_acc_re", acc_re, 0);
      chk("rst_acc_im", acc_im, 0);
      rst = 1'b0;
      tick();

      load4(a, b);
      run(1'b0, 1'b0, -20, 40, "normal");

      load4(a, b);
      run(1'b1, 1'b0, 44, 8, "conj");

      load4(m, m);
      run(1'b0, 1'b0, 0, 512, "ext_norm");
      load4(m, m);
      run(1'b1, 1'b0, 512, 0, "ext_conj");

      load4(a, b);
      run(1'b0, 1'b0, -20, 40, "keep_first");
      load4(a, b);
      chk("keep_hold_re", acc_re, -20);
      chk("keep_hold_im", acc_im, 40);
      run(1'b0, 1'b1, -40, 80, "keep_second");

      load(a, b);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("hs_start_ignored_busy", busy, 0);
      chk("hs_start_ignored_rdy", in_ready, 1);
      load(a, b);
      tick();
      tick();
      load(a, b);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("hs_gap_busy", busy, 0);
      load(a, b);
      chk("hs_ready_drop", in_ready, 0);
      in_valid = 1'b1;
      x_in     = m;
      y_in     = m;
      tick();
      in_valid = 1'b0;
      chk("hs_full_no_accept", in_ready, 0);

      conj  = 1'b0;
      keep  = 1'b0;
      start = 1'b1;
      tick();
      tick();
      tick();
      start = 1'b0;
      dc  = 0;
      sre = '0;
      sim = '0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin
            dc++;
            sre = acc_re;
            sim = acc_im;
         end
         tick();
      end
      chk("hold_start_dones", dc, 1);
      chk("hold_start_re", sre, -20);
      chk("hold_start_im", sim, 40);

      load4(a, b);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("abort_busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_done", done, 0);
      chk("abort_acc_re", acc_re, 0);
      chk("abort_acc_im", acc_im, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      dc = 0;
      for (int k = 0; k < 6; k++) begin
         if (done) dc++;
         tick();
      end
      chk("abort_no_done", dc, 0);
      load4(a, b);
      run(1'b0, 1'b0, -20, 40, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmplx_mac_engine.md
# cmplx_mac_engine

Parametrised complex multiply-accumulate engine: it buffers `N` complex operand pairs through a valid/ready load port, then computes Σ x_i·y_i or Σ x_i·conj(y_i) at one product per cycle. It succeeds the fixed 4-pair, 4-bit datapath with its external controller:

- width and depth are parameters;
- the load/run sequencing is internal;
- the imaginary path is fully signed;
- it supports a conjugate mode and an accumulate-across-runs mode.

It sits between the operand source and the result consumer in the MAC subsystem.

## Interface
Parameters:
- `N`, 4: number of complex pairs per run (≥2).
- `CW`, 4: width of each real/imag component, two's complement.
- `ACCW`, 2*CW+1+$clog2(N): accumulator component width (derived; do not override).

Ports:
- `clk`  in  1  clock, rising edge; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  engine accepts a pair this cycle.
- `x_in`  in  2*CW  packed complex {re, im}; re in upper half.
- `y_in`  in  2*CW  packed complex {re, im}.
- `start`  in  1  begin a run; honoured only in FULL.
- `conj`  in  1  sampled with start; 1 selects x·conj(y).
- `keep`  in  1  sampled with start; 1 keeps the accumulator instead of clearing it.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse; result valid.
- `acc_re`  out  ACCW  signed real accumulator.
- `acc_im`  out  ACCW  signed imag accumulator.

## Operation
- States are LOAD, FULL, RUN and DRAIN; reset enters LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid`&`in_ready` writes slot `wr_idx`, then `wr_idx`++.
  - The handshake on slot N-1 moves to FULL.
  - `start` is ignored.
- **FULL**
  - `in_ready`=0.
  - `start`=1 latches `conj` and `keep`, clears the accumulator if `keep`=0, sets `rd_idx`=0 and moves to RUN.
  - `start` held high for several cycles counts once.
- **RUN**
  - Each cycle registers product(`rd_idx`) into the product register, then `rd_idx`++.
  - The accumulator adds the previous product.
  - After issuing slot N-1, move to DRAIN.
- **DRAIN**
  - Adds the final product, sets `done`, returns to LOAD with `wr_idx`=0.
  - Slot contents are retained but are overwritten by the next load.
- Arithmetic: all values are signed; CW×CW products are 2CW bits.
  - Normal mode: re = xr·yr − xi·yi; im = xr·yi + xi·yr.
  - Conj mode: re = xr·yr + xi·yi; im = xi·yr − xr·yi.
  - Products are sign-extended to ACCW; accumulation wraps modulo 2^ACCW.
  - The default ACCW cannot overflow within one run. Overflow across `keep` runs is the user's responsibility.
- `acc_re`/`acc_im` are register outputs.
  - They change only during a run and hold their value otherwise.
  - A run with `keep`=0 clears them at the start edge.
- `in_valid` is ignored outside LOAD; no data is dropped, because `in_ready`=0.
- Reset mid-run aborts the run: no `done`, and all state returns to reset values.

## Timing
- Reset values:
  - `in_ready`=1 (LOAD).
  - `busy`=0, `done`=0.
  - `acc_re`=0, `acc_im`=0.
  - `wr_idx`=0, `rd_idx`=0, product register and slots = 0.
- Let E0 be the edge where `start` is sampled in FULL:
  - The product register captures slots 0..N-1 at edges E1..EN.
  - The accumulator adds them at E2..EN+1.
  - `done`=1 for exactly the cycle following EN+1, which is N+1 cycles after E0.
  - The final `acc_*` is visible in that same cycle.
- `busy` is high from after E0 through the cycle ending at EN+1, i.e. in RUN and DRAIN.
- `in_ready` rises in the `done` cycle, so a new pair can be accepted in that cycle.
- Load throughput: one pair per cycle. Minimum back-to-back period is N (load) + 1 (start) + N+1 (run).

## Structure
- Package `cmac_pkg`:
  - state enum `cmac_state_t` {LOAD, FULL, RUN, DRAIN};
  - function `cmac_accw(N, CW)`;
  - pack/unpack helpers for {re, im}.
- Sub-module `cmplx_mult`: combinational signed CW×CW complex multiplier with a `conj` input, producing 2CW+1-bit re/im.
- Top level holds:
  - the slot register arrays;
  - the FSM;
  - the `wr_idx`/`rd_idx` counters;
  - the product register;
  - the accumulators.

## Test plan
Default parameters (N=4, CW=4) throughout.
- **Normal mode:** load 4× (x=1+2j, y=3+4j), `start`, `conj`=0, `keep`=0 → `done` 5 cycles after the start edge; acc = −20+40j; `busy` high for 5 cycles.
- **Conj mode:** same data with `conj`=1 → acc = 44+8j.
- **Extremes:**
  - 4× (x=y=−8−8j), `conj`=0 → 0+512j.
  - `conj`=1 → 512+0j.
- **Keep mode:** a run yielding −20+40j, then reload the same data and start with `keep`=1 → acc = −40+80j.
- **Handshake:**
  - `in_valid` with gaps and `start` pulsed during LOAD → start ignored, `in_ready` drops after the 4th pair;
  - `start` held 3 cycles → exactly one `done`.
- **Reset mid-run:** assert `rst` 2 cycles into RUN → no `done`, acc=0, `in_ready`=1, next full sequence gives the correct result.
